// File: rtl/stage_pattern_seq_if.sv
// Bus bundle for the staged pattern sequencer: control, pattern-store write
// port, and the registered sequencer outputs.
// master drives control/writes and observes outputs; slave is the sequencer.
interface stage_pattern_seq_if #(
    parameter int NCH   = 3,
    parameter int DW    = 2,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              run;
    logic              oneshot;
    logic [NCH-1:0]    stage_on;
    logic              wr_en;
    logic [CW-1:0]     wr_ch;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NCH*DW-1:0] data;
    logic [AW-1:0]     step;
    logic              wrap;
    logic              busy;

    modport master (
        output run, oneshot, stage_on, wr_en, wr_ch, wr_addr, wr_data,
        input  data, step, wrap, busy
    );

    modport slave (
        input  run, oneshot, stage_on, wr_en, wr_ch, wr_addr, wr_data,
        output data, step, wrap, busy
    );
endinterface

// File: rtl/stage_pattern_seq.sv
// Purpose: multi-channel step pattern sequencer with a register pattern store,
//          loop / one-shot modes and per-channel output gating.
// Latency: data is registered one cycle after the step it reflects; step/wrap/busy
//          are registered with the FSM. Backpressure: none, run is a level
//          request that pauses the sequence when low.
// Ports: clk, rst (sync active-high), bus (stage_pattern_seq_if.slave).
module stage_pattern_seq #(
    parameter int NCH   = 3,
    parameter int DW    = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    stage_pattern_seq_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] LAST_STEP = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [NCH-1:0][DEPTH-1:0][DW-1:0] store_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;
    logic [NCH*DW-1:0] data_q, data_d;
    store_t            store_q, store_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    // Pause: position is kept so a later run resumes in place.
                    state_d = ST_IDLE;
                end else if (step_q == LAST_STEP) begin
                    wrap_d = 1'b1;
                    if (bus.oneshot) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d = '0;
                    end
                end else begin
                    step_d = step_q + AW'(1);
                end
            end
            ST_DONE: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // Output lanes read the store before this cycle's write lands, so a
    // same-entry collision shows the old value.
    always_comb begin
        data_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.stage_on[k]) begin
                data_d[k*DW +: DW] = store_q[k][step_q];
            end
        end
    end

    // Channel select by explicit match so out-of-range wr_ch hits no channel.
    always_comb begin
        store_d = store_q;
        if (bus.wr_en) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.wr_ch == CW'(k)) begin
                    store_d[k][bus.wr_addr] = bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            store_q <= store_d;
        end
    end

    assign bus.data = data_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_stage_pattern_seq.sv
module tb_stage_pattern_seq;
    localparam int NCH   = 3;
    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 2;

    logic clk;
    logic rst;

    stage_pattern_seq_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

    stage_pattern_seq #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*DW-1:0] data;
        logic [AW-1:0]     step;
        logic              wrap;
        logic              busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase 0=idle, 1=running, 2=finished one-shot.
    int m_phase = 0;
    int m_pos   = 0;
    int m_mem [NCH][DEPTH];

    task automatic chk(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, field, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle after an issued stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "data", 32'(bus.data), 32'(e.data));
                chk(nm, "step", 32'(bus.step), 32'(e.step));
                chk(nm, "wrap", 32'(bus.wrap), 32'(e.wrap));
                chk(nm, "busy", 32'(bus.busy), 32'(e.busy));
            end
        end
    end

    // Apply one cycle of inputs (at negedge), predict the post-edge outputs.
    task automatic drive(input logic r, input logic ru, input logic os,
                         input logic [NCH-1:0] so, input logic we,
                         input logic [CW-1:0] wc, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input string nm);
        exp_t e;
        rst          = r;
        bus.run      = ru;
        bus.oneshot  = os;
        bus.stage_on = so;
        bus.wr_en    = we;
        bus.wr_ch    = wc;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;

        e.data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (so[k]) e.data[k*DW +: DW] = DW'(m_mem[k][m_pos]);
        end
        e.wrap = 1'b0;

        if (r) begin
            m_phase = 0;
            m_pos   = 0;
            e.data  = '0;
            for (int k = 0; k < NCH; k++)
                for (int a = 0; a < DEPTH; a++) m_mem[k][a] = 0;
        end else begin
            e.wrap = (m_phase == 1 && ru && m_pos == DEPTH - 1);
            if (m_phase == 0) begin
                if (ru) m_phase = 1;
            end else if (m_phase == 1) begin
                if (!ru) m_phase = 0;
                else if (m_pos == DEPTH - 1 && os) m_phase = 2;
                else m_pos = (m_pos + 1) % DEPTH;
            end else begin
                if (!ru) begin
                    m_phase = 0;
                    m_pos   = 0;
                end
            end
            if (we && int'(wc) < NCH) m_mem[wc][wa] = int'(wd);
        end
        e.step = AW'(m_pos);
        e.busy = (m_phase == 1);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cyc(input logic ru, input logic os, input logic [NCH-1:0] so,
                            input string nm);
        drive(1'b0, ru, os, so, 1'b0, '0, '0, '0, nm);
    endtask

    task automatic load_ch0_pattern();
        logic [DW-1:0] pat [DEPTH];
        pat = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int a = 0; a < DEPTH; a++)
            drive(1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, AW'(a), pat[a], "load");
    endtask

    initial begin
        for (int k = 0; k < NCH; k++)
            for (int a = 0; a < DEPTH; a++) m_mem[k][a] = 0;
        rst          = 1'b1;
        bus.run      = 1'b0;
        bus.oneshot  = 1'b0;
        bus.stage_on = '0;
        bus.wr_en    = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        @(negedge clk);

        // Reset with arbitrary inputs, then read every step of every lane.
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b1, 1'($urandom), 3'b111, 1'b1, CW'($urandom), AW'($urandom),
                  DW'($urandom), "reset");
        for (int i = 0; i < DEPTH + 2; i++) idle_cyc(1'b1, 1'b0, 3'b111, "reset_store");
        idle_cyc(1'b0, 1'b0, 3'b111, "reset_stop");

        // Loop mode on channel 0.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, '0, '0, '0, "reset2");
        load_ch0_pattern();
        for (int i = 0; i < 10; i++) idle_cyc(1'b1, 1'b0, 3'b001, "loop");
        for (int i = 0; i < 2; i++) idle_cyc(1'b0, 1'b0, 3'b001, "pause");

        // One-shot: realign to step 0 via a finished one-shot, then run again.
        for (int i = 0; i < 8; i++) idle_cyc(1'b1, 1'b1, 3'b001, "oneshot_a");
        idle_cyc(1'b0, 1'b1, 3'b001, "oneshot_clr");
        for (int i = 0; i < 8; i++) idle_cyc(1'b1, 1'b1, 3'b001, "oneshot");
        idle_cyc(1'b0, 1'b1, 3'b001, "oneshot_clr2");
        idle_cyc(1'b0, 1'b0, 3'b001, "oneshot_idle");

        // Gating: all entries 3, lane 1 disabled.
        for (int k = 0; k < NCH; k++)
            for (int a = 0; a < DEPTH; a++)
                drive(1'b0, 1'b0, 1'b0, 3'b101, 1'b1, CW'(k), AW'(a), 2'd3, "gate_load");
        for (int i = 0; i < 2; i++) idle_cyc(1'b0, 1'b0, 3'b101, "gating");

        // Collision: write ch0 step 2 while it is being read.
        load_ch0_pattern();
        for (int i = 0; i < 16 && !(m_phase == 1 && m_pos == 2); i++)
            idle_cyc(1'b1, 1'b0, 3'b001, "coll_seek");
        drive(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0, 2'd2, 2'd3, "collision");
        for (int i = 0; i < 6; i++) idle_cyc(1'b1, 1'b0, 3'b001, "coll_after");

        // Illegal channel write must not alias onto any lane.
        drive(1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 2'd1, 2'd2, "illegal_wr");
        for (int i = 0; i < 6; i++) idle_cyc(1'b1, 1'b0, 3'b111, "illegal_chk");

        // Reset mid-run at step 2.
        for (int i = 0; i < 16 && !(m_phase == 1 && m_pos == 2); i++)
            idle_cyc(1'b1, 1'b0, 3'b111, "rst_seek");
        drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 2'd1, 2'd0, 2'd1, "rst_midrun");
        for (int i = 0; i < 6; i++) idle_cyc(1'b0, 1'b0, 3'b111, "rst_after");

        // Randomized traffic.
        for (int i = 0; i < 800; i++)
            drive(1'(($urandom % 97) == 0), 1'(($urandom % 6) != 0), 1'(($urandom % 3) == 0),
                  NCH'($urandom), 1'(($urandom % 3) == 0), CW'($urandom), AW'($urandom),
                  DW'($urandom), "random");

        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/stage_pattern_seq.md
STAGE_PATTERN_SEQ -- requirements
Module: stage_pattern_seq

Interface
REQ-001 Parameter NCH, default 3, number of stage channels (1..8).
REQ-002 Parameter DW, default 2, pattern data width per channel (1..8).
REQ-003 Parameter DEPTH, default 4, pattern steps per channel; power of two, 2..64; AW = log2(DEPTH); CW = max(1, ceil(log2(NCH))).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high; the clock port is named clk and the reset port is named rst.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 run  in  1  step-advance request; level-sensitive.
REQ-008 oneshot  in  1  mode select: 0 = loop, 1 = stop after last step.
REQ-009 stage_on  in  NCH  per-channel output enable; bit k gates channel k.
REQ-010 wr_en  in  1  pattern write strobe.
REQ-011 wr_ch  in  CW  channel written.
REQ-012 wr_addr  in  AW  step index written.
REQ-013 wr_data  in  DW  pattern value written.
REQ-014 data  out  NCH*DW  channel k at bits [k*DW +: DW]; registered.
REQ-015 step  out  AW  current step counter; registered.
REQ-016 wrap  out  1  one-cycle pulse on last-step completion.
REQ-017 busy  out  1  high while state is RUN.

Function
REQ-018 Pattern store SHALL hold NCH x DEPTH entries of DW bits, implemented as registers.
REQ-019 When wr_en=1 and wr_ch<NCH, entry [wr_ch][wr_addr] SHALL take wr_data at the clock edge; writes with wr_ch>=NCH SHALL be ignored; writes are accepted in every state.
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 IDLE: run=1 -> RUN; otherwise stay; step holds.
REQ-022 RUN, run=0 -> IDLE, step holds its value (pause).
REQ-023 RUN, run=1, step<DEPTH-1 -> step increments by 1, stay in RUN.
REQ-024 RUN, run=1, step=DEPTH-1, oneshot=0 -> step wraps to 0, stay in RUN, wrap=1 next cycle.
REQ-025 RUN, run=1, step=DEPTH-1, oneshot=1 -> step holds DEPTH-1, go to DONE, wrap=1 next cycle.
REQ-026 DONE: run=1 -> stay, step holds; run=0 -> IDLE with step cleared to 0.
REQ-027 wrap SHALL be registered, high for exactly one cycle per last-step completion, low otherwise.
REQ-028 oneshot is sampled every cycle; changing it mid-run only affects the next last-step decision.
REQ-029 busy SHALL equal (state==RUN), registered with state.
REQ-030 data channel k SHALL register (stage_on[k] ? store[k][step] : 0), using step and stage_on values present before the edge; latency one cycle from step to data.
REQ-031 Write and read of the same entry in one cycle: data SHALL show the old value; new value appears on the next read of that entry.
REQ-032 Step arithmetic is modulo DEPTH; no other width extension or saturation.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, step=0, data=0, wrap=0, busy=0, all store entries=0.
REQ-034 rst SHALL take priority over run and wr_en in the same cycle; a reset mid-RUN discards the position.
REQ-035 After rst deasserts, the first edge with run=1 enters RUN; step advances from that edge's next edge.

Verification
REQ-036 Reset: drive arbitrary inputs with rst=1 two cycles -> data=0, step=0, wrap=0, busy=0, store reads 0.
REQ-037 Loop (NCH=3,DW=2,DEPTH=4): load ch0={1,2,3,0}, stage_on=3'b001, run=1, oneshot=0 -> ch0 data 1,2,3,0,1 on successive cycles; wrap high one cycle after step 3->0.
REQ-038 Oneshot: same load, oneshot=1 -> step 0,1,2,3 then holds 3, state DONE, busy=0, one wrap pulse; run=0 -> step=0, IDLE.
REQ-039 Gating: all channels loaded 2'b11, stage_on=3'b101 -> data=6'b110011 after one cycle; channel 1 stays 0.
REQ-040 Collision/illegal write: write ch0 step 2 =3 while reading step 2 -> old value out, 3 on next pass; wr_ch=3 with NCH=3 -> no store change.
REQ-041 Reset mid-run: rst at step 2 during RUN -> next cycle step=0, IDLE, data=0, store cleared.
